// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator.
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_e;

  // Size code 3 is reserved and reported as misaligned so it never reaches memory.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = addr_lo[0];
      SZ_W:    is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replication and load extract with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    wstrb      = 4'b1111;
    lane_wdata = store_data;
    case (size)
      SZ_B: begin
        wstrb      = 4'b0001 << addr_lo;
        lane_wdata = {4{store_data[7:0]}};
      end
      SZ_H: begin
        wstrb      = 4'b0011 << addr_lo;
        lane_wdata = {2{store_data[15:0]}};
      end
      default: begin
        wstrb      = 4'b1111;
        lane_wdata = store_data;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend to the full word.
  always_comb begin
    shifted   = mem_rdata >> {addr_lo, 3'b000};
    load_data = shifted;
    case (size)
      SZ_B:    load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store initiator: one request at a time to a variable-latency data memory,
// with misalignment and optional timeout reporting.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic                    resp_valid_o,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_err_o,
  output logic                    busy_o,
  output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
  output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] dmem_wstrb_o,
  output logic                    dmem_write_o,
  output logic                    dmem_read_o,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
  input  logic                    dmem_ready_i
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                  state;
  logic [CW-1:0]           cnt;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [1:0]              cap_size;
  logic                    cap_we;
  logic                    cap_unsigned;
  logic [DATA_WIDTH-1:0]   cap_wdata;
  logic [3:0]              lane_strb;
  logic [31:0]             lane_wdata;
  logic [31:0]             load_data;

  lsu_align u_align (
    .size        (cap_size),
    .addr_lo     (cap_addr[1:0]),
    .is_unsigned (cap_unsigned),
    .store_data  (cap_wdata),
    .mem_rdata   (dmem_rdata_i),
    .wstrb       (lane_strb),
    .lane_wdata  (lane_wdata),
    .load_data   (load_data)
  );

  // Address and lane data come from the captured request, so they stay steady across REQ.
  assign dmem_addr_o  = (state == S_REQ) ? {cap_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dmem_wstrb_o = (state == S_REQ && cap_we) ? lane_strb : '0;
  assign dmem_wdata_o = (state == S_REQ && cap_we) ? lane_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      req_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      dmem_read_o  <= 1'b0;
      dmem_write_o <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
      cnt          <= '0;
      cap_addr     <= '0;
      cap_size     <= '0;
      cap_we       <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_wdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            cap_addr     <= req_addr_i;
            cap_size     <= req_size_i;
            cap_we       <= req_we_i;
            cap_unsigned <= req_unsigned_i;
            cap_wdata    <= req_wdata_i;
            cnt          <= '0;
            req_ready_o  <= 1'b0;
            busy_o       <= 1'b1;
            if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
              state        <= S_RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_rdata_o <= '0;
            end else begin
              state        <= S_REQ;
              dmem_read_o  <= ~req_we_i;
              dmem_write_o <= req_we_i;
            end
          end
        end
        S_REQ: begin
          // Ready is checked first so a completion on the expiry cycle still succeeds.
          if (dmem_ready_i) begin
            state        <= S_RESP;
            dmem_read_o  <= 1'b0;
            dmem_write_o <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= cap_we ? '0 : load_data;
          end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) begin
            state        <= S_RESP;
            dmem_read_o  <= 1'b0;
            dmem_write_o <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            resp_rdata_o <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          state        <= S_IDLE;
          resp_valid_o <= 1'b0;
          resp_err_o   <= 1'b0;
          resp_rdata_o <= '0;
          req_ready_o  <= 1'b1;
          busy_o       <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store initiator sitting between the pipelined core's memory stage and a variable-latency data memory (read/write/ready responder such as mem_nzlat). Accepts one byte/half/word request at a time from the core. Generates aligned address, write strobes and lane-shifted write data, and holds read/write until the memory pulses ready. Returns sign/zero-extended load data, or an error for misaligned or timed-out accesses.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, memory data width (fixed 32 in this revision)
TIMEOUT_CYCLES, 256, max cycles in REQ waiting for dmem_ready_i before error; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  high in IDLE; request accepted when valid&ready
req_we_i  in  1  1 store, 0 load
req_size_i  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as misaligned)
req_unsigned_i  in  1  zero-extend load (LBU/LHU)
req_addr_i  in  ADDR_WIDTH  byte address
req_wdata_i  in  DATA_WIDTH  store data, LSB-justified
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  DATA_WIDTH  extended load data (0 for stores/errors)
resp_err_o  out  1  misaligned or timeout, valid with resp_valid_o
busy_o  out  1  not IDLE
dmem_addr_o  out  ADDR_WIDTH  word-aligned address (addr[1:0]=0)
dmem_wdata_o  out  DATA_WIDTH  lane-shifted store data
dmem_wstrb_o  out  DATA_WIDTH/8  byte strobes
dmem_write_o  out  1  write request level
dmem_read_o  out  1  read request level
dmem_rdata_i  in  DATA_WIDTH  read data, valid when dmem_ready_i high
dmem_ready_i  in  1  memory completion pulse

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0 except req_ready_o=1; timeout counter 0; captured request regs 0.
- States: IDLE, REQ, RESP.
- IDLE: req_valid_i & req_ready_o captures addr, size, we, unsigned, wdata. If misaligned (half with addr[0]=1, word with addr[1:0]!=0, size 3) go RESP with err=1, no memory access. Otherwise go REQ.
- REQ: dmem_read_o=~we or dmem_write_o=we, held steady along with addr/wdata/wstrb every cycle until dmem_ready_i is sampled high. Then go RESP and capture the extended rdata. Counter increments each REQ cycle; at TIMEOUT_CYCLES go RESP with err=1.
- RESP: read/write low; resp_valid_o=1 for exactly one cycle; return to IDLE. req_ready_o=0 here, so back-to-back requests are spaced by at least one idle cycle.
- Latency: accept at cycle 0; dmem_* asserted cycle 1; ready sampled at cycle k gives resp_valid_o at cycle k+1. Misaligned: resp at cycle 1.
- Strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. Stores are never read-modify-write.
- wdata: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- Load extract: shift rdata right by 8*addr[1:0], take 8/16/32 bits, sign-extend unless unsigned.
- dmem_ready_i outside REQ is ignored, with no state change. Ready in the same cycle the timeout expires counts as success.
- rst_n asserted mid-REQ drops read/write asynchronously and issues no response.

Decomposition:
- Package lsu_pkg: typedef enum logic[1:0] {SZ_B, SZ_H, SZ_W} size_e; state enum {S_IDLE, S_REQ, S_RESP}; function is_misaligned(size, addr[1:0]).
- Sub-module lsu_align (combinational): generates wstrb and wdata replication, and performs load extract and sign extension. FSM, capture registers and counter stay in lsu_mem_if.

Test Plan:
- SW addr 0x104 wdata 0xdeadbeef, memory ready after 5 cycles → dmem_write_o held 5 cycles with addr 0x104, wstrb 1111; resp_valid_o 1 cycle later, err=0.
- LB addr 0x103, memory word 0x80FF_0000 → wstrb ignored, resp_rdata_o=0xFFFFFF80. Same with LBU → 0x00000080. LH addr 0x102 → 0xFFFF80FF.
- SB addr 0x201 wdata 0x000000AB → dmem_wstrb_o=0010, dmem_wdata_o=0xABABABAB, dmem_addr_o=0x200.
- LW addr 0x102 → no dmem_read_o ever asserted; resp_valid_o at cycle 1 with err=1, rdata=0.
- TIMEOUT_CYCLES=8, memory never readies → read drops after 8 REQ cycles; resp err=1; busy_o returns 0. A stray dmem_ready_i pulse in IDLE produces no response.
- rst_n pulsed low during REQ → dmem_read_o low immediately; no resp_valid_o; next request completes normally.
